multi_channel_pulse_width_detector: RTL and testbench



---
 rtl/pulse_det_pkg.sv | 18 +
 rtl/pulse_width_channel.sv | 66 ++++++
 rtl/multi_channel_pulse_width_detector.sv | 59 +++++
 tb/tb_multi_channel_pulse_width_detector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_det_pkg.sv
// rtl/pulse_det_pkg.sv - shared types and constants for the multi-channel pulse width detector
package pulse_det_pkg;

   localparam int DEF_N_CH  = 4;
   localparam int DEF_CNT_W = 8;

   // Largest representable pulse length; longer pulses stick at this value.
   function automatic logic [31:0] sat_val(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   typedef struct packed {
      logic rise;
      logic fall;
      logic detected;
   } ch_event_t;

endpackage

// File: rtl/pulse_width_channel.sv
// rtl/pulse_width_channel.sv - one channel: edge detect, saturating length count, window match
module pulse_width_channel
   import pulse_det_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_i,
   input  logic [CNT_W-1:0] min_len_i,
   input  logic [CNT_W-1:0] max_len_i,
   output ch_event_t        ev_o,
   output logic [CNT_W-1:0] pulse_len_o
);

   localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic             a_r_q, a_r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   ch_event_t        ev_q, ev_d;
   logic [CNT_W-1:0] min_eff;
   logic             in_window;

   // A zero lower bound is treated as 1 so an empty window cannot match a real pulse.
   assign min_eff   = (min_len_i == '0) ? ONE : min_len_i;
   assign in_window = (cnt_q >= min_eff) && (cnt_q <= max_len_i);

   always_comb begin
      a_r_d = a_i;
      cnt_d = cnt_q;
      len_d = len_q;
      ev_d  = '0;
      if (a_i && !a_r_q) begin
         cnt_d   = ONE;
         ev_d.rise = 1'b1;
      end else if (a_i && a_r_q) begin
         if (cnt_q != SAT) begin
            cnt_d = cnt_q + ONE;
         end
      end else if (!a_i && a_r_q) begin
         ev_d.fall     = 1'b1;
         ev_d.detected = in_window;
         len_d         = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r_q <= 1'b0;
         cnt_q <= '0;
         len_q <= '0;
         ev_q  <= '0;
      end else begin
         a_r_q <= a_r_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         ev_q  <= ev_d;
      end
   end

   assign ev_o        = ev_q;
   assign pulse_len_o = len_q;

endmodule

// File: rtl/multi_channel_pulse_width_detector.sv
// rtl/multi_channel_pulse_width_detector.sv - N_CH pulse width detectors; PULSE_DET_SYNC_EN adds a 2-flop input synchronizer
module multi_channel_pulse_width_detector
   import pulse_det_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CH-1:0]            a,
   input  logic [CNT_W-1:0]           min_len,
   input  logic [CNT_W-1:0]           max_len,
   output logic [N_CH-1:0]            rise,
   output logic [N_CH-1:0]            fall,
   output logic [N_CH-1:0]            detected,
   output logic [N_CH-1:0][CNT_W-1:0] pulse_len
);

   logic [N_CH-1:0] a_s;

`ifdef PULSE_DET_SYNC_EN
   logic [N_CH-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= a;
         sync2_q <= sync1_q;
      end
   end

   assign a_s = sync2_q;
`else
   assign a_s = a;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ch_event_t ev;

      pulse_width_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .a_i        (a_s[i]),
         .min_len_i  (min_len),
         .max_len_i  (max_len),
         .ev_o       (ev),
         .pulse_len_o(pulse_len[i])
      );

      assign rise[i]     = ev.rise;
      assign fall[i]     = ev.fall;
      assign detected[i] = ev.detected;
   end

endmodule

// File: tb/tb_multi_channel_pulse_width_detector.sv
// tb/tb_multi_channel_pulse_width_detector.sv - directed table and sequence bench for the pulse width detector
module tb_multi_channel_pulse_width_detector;

   localparam int N_CH  = 4;
   localparam int CNT_W = 4;
`ifdef PULSE_DET_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic                       clk = 1'b0;
   logic                       rst;
   logic [N_CH-1:0]            a;
   logic [CNT_W-1:0]           min_len, max_len;
   logic [N_CH-1:0]            rise, fall, detected;
   logic [N_CH-1:0][CNT_W-1:0] pulse_len;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  mn;
      logic [3:0]  mx;
      logic [3:0]  rise;
      logic [3:0]  fall;
      logic [3:0]  det;
      logic [15:0] len;
   } vec_t;

   vec_t tv[$];

   multi_channel_pulse_width_detector #(
      .N_CH (N_CH),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .min_len  (min_len),
      .max_len  (max_len),
      .rise     (rise),
      .fall     (fall),
      .detected (detected),
      .pulse_len(pulse_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic add(input logic [3:0] av, input logic [3:0] mn, input logic [3:0] mx,
                      input logic [3:0] r, input logic [3:0] f, input logic [3:0] d,
                      input logic [15:0] len);
      vec_t v;
      v.a = av; v.mn = mn; v.mx = mx; v.rise = r; v.fall = f; v.det = d; v.len = len;
      tv.push_back(v);
   endtask

   initial begin
      vec_t e;
      int   nv;

      // window [1,1]: single 010 pulse, a 2-long pulse, then back-to-back 1,0,1,0
      add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0000);
      add(4'h1, 1, 1, 4'h1, 4'h0, 4'h0, 16'h0000);
      add(4'h0, 1, 1, 4'h0, 4'h1, 4'h1, 16'h0001);
      add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0001);
      add(4'h1, 1, 1, 4'h1, 4'h0, 4'h0, 16'h0001);
      add(4'h1, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0001);
      add(4'h0, 1, 1, 4'h0, 4'h1, 4'h0, 16'h0002);
      add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0002);
      add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0002);
      add(4'h1, 1, 1, 4'h1, 4'h0, 4'h0, 16'h0002);
      add(4'h0, 1, 1, 4'h0, 4'h1, 4'h1, 16'h0001);
      add(4'h1, 1, 1, 4'h1, 4'h0, 4'h0, 16'h0001);
      add(4'h0, 1, 1, 4'h0, 4'h1, 4'h1, 16'h0001);
      add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0001);
      add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0001);
      // window [2,4]: ch1 pulses of length 1, 3, 5
      add(4'h2, 2, 4, 4'h2, 4'h0, 4'h0, 16'h0001);
      add(4'h0, 2, 4, 4'h0, 4'h2, 4'h0, 16'h0011);
      add(4'h0, 2, 4, 4'h0, 4'h0, 4'h0, 16'h0011);
      add(4'h2, 2, 4, 4'h2, 4'h0, 4'h0, 16'h0011);
      add(4'h2, 2, 4, 4'h0, 4'h0, 4'h0, 16'h0011);
      add(4'h2, 2, 4, 4'h0, 4'h0, 4'h0, 16'h0011);
      add(4'h0, 2, 4, 4'h0, 4'h2, 4'h2, 16'h0031);
      add(4'h0, 2, 4, 4'h0, 4'h0, 4'h0, 16'h0031);
      add(4'h2, 2, 4, 4'h2, 4'h0, 4'h0, 16'h0031);
      for (int i = 0; i < 4; i++) add(4'h2, 2, 4, 4'h0, 4'h0, 4'h0, 16'h0031);
      add(4'h0, 2, 4, 4'h0, 4'h2, 4'h0, 16'h0051);
      add(4'h0, 2, 4, 4'h0, 4'h0, 4'h0, 16'h0051);
      add(4'h0, 2, 4, 4'h0, 4'h0, 4'h0, 16'h0051);
      // window [2,2]: ch0 and ch3 fall together
      add(4'h9, 2, 2, 4'h9, 4'h0, 4'h0, 16'h0051);
      add(4'h9, 2, 2, 4'h0, 4'h0, 4'h0, 16'h0051);
      add(4'h0, 2, 2, 4'h0, 4'h9, 4'h9, 16'h2052);
      add(4'h0, 2, 2, 4'h0, 4'h0, 4'h0, 16'h2052);
      add(4'h0, 2, 2, 4'h0, 4'h0, 4'h0, 16'h2052);
      // window [0,1]: zero lower bound acts as 1
      add(4'h4, 0, 1, 4'h4, 4'h0, 4'h0, 16'h2052);
      add(4'h0, 0, 1, 4'h0, 4'h4, 4'h4, 16'h2152);
      add(4'h0, 0, 1, 4'h0, 4'h0, 4'h0, 16'h2152);
      add(4'h0, 0, 1, 4'h0, 4'h0, 4'h0, 16'h2152);
      // window [3,2]: inverted bounds never match
      add(4'h4, 3, 2, 4'h4, 4'h0, 4'h0, 16'h2152);
      add(4'h4, 3, 2, 4'h0, 4'h0, 4'h0, 16'h2152);
      add(4'h4, 3, 2, 4'h0, 4'h0, 4'h0, 16'h2152);
      add(4'h0, 3, 2, 4'h0, 4'h4, 4'h0, 16'h2352);
      add(4'h0, 3, 2, 4'h0, 4'h0, 4'h0, 16'h2352);
      add(4'h0, 3, 2, 4'h0, 4'h0, 4'h0, 16'h2352);

      rst = 1'b1; a = '0; min_len = 4'd1; max_len = 4'd1;
      #12;
      chk("reset_rise", 32'(rise), 32'h0);
      chk("reset_fall", 32'(fall), 32'h0);
      chk("reset_det",  32'(detected), 32'h0);
      chk("reset_len",  32'(pulse_len), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      nv = tv.size();
      for (int k = 0; k < nv + LAT; k++) begin
         if (k < nv) begin
            a = tv[k].a; min_len = tv[k].mn; max_len = tv[k].mx;
         end
         step(1);
         if (k >= LAT) begin
            e = tv[k - LAT];
            chk($sformatf("vec%0d_rise", k - LAT), 32'(rise), 32'(e.rise));
            chk($sformatf("vec%0d_fall", k - LAT), 32'(fall), 32'(e.fall));
            chk($sformatf("vec%0d_det",  k - LAT), 32'(detected), 32'(e.det));
            chk($sformatf("vec%0d_len",  k - LAT), 32'(pulse_len), 32'(e.len));
         end else begin
            chk($sformatf("lead%0d_rise", k), 32'(rise), 32'h0);
            chk($sformatf("lead%0d_len", k), 32'(pulse_len), 32'h0);
         end
      end

      // 20-sample pulse saturates at 15: misses with max=14, hits with max=15
      for (int pass = 0; pass < 2; pass++) begin
         min_len = 4'd1;
         max_len = (pass == 0) ? 4'd14 : 4'd15;
         a = 4'h4;
         step(1 + LAT);
         chk($sformatf("sat%0d_rise", pass), 32'(rise), 32'h4);
         step(19 - LAT);
         a = 4'h0;
         step(1 + LAT);
         chk($sformatf("sat%0d_fall", pass), 32'(fall), 32'h4);
         chk($sformatf("sat%0d_det", pass), 32'(detected), (pass == 0) ? 32'h0 : 32'h4);
         chk($sformatf("sat%0d_len2", pass), 32'(pulse_len[2]), 32'd15);
         step(1);
         chk($sformatf("sat%0d_strobe_once", pass), 32'({fall, detected}), 32'h0);
         step(2);
      end

      // reset in the middle of a ch1 pulse, with a held high across release
      min_len = 4'd1; max_len = 4'd15;
      a = 4'h2;
      step(1 + LAT);
      chk("rst_pre_rise", 32'(rise), 32'h2);
      step(6);
      rst = 1'b1;
      #1;
      chk("rst_async_outs", 32'({rise, fall, detected}), 32'h0);
      chk("rst_async_len", 32'(pulse_len), 32'h0);
      step(1);
      rst = 1'b0;
      step(1 + LAT);
      chk("rst_post_rise", 32'(rise), 32'h2);
      step(2);
      a = 4'h0;
      step(1 + LAT);
      chk("rst_post_fall", 32'(fall), 32'h2);
      chk("rst_post_det", 32'(detected), 32'h2);
      chk("rst_post_len", 32'(pulse_len), 32'((3 + LAT) << 4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
